// File: rtl/bp_resolve_queue.sv
// In-flight branch queue: holds predictor indices and predicted direction from F until the
// branch resolves in M, then issues a one-cycle predictor update. Optional macro: BP_STATS_EN.
module bp_resolve_queue #(
   parameter int BHT_DEPTH  = 3,
   parameter int QDEPTH_LOG = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pushF,
   input  logic [BHT_DEPTH-1:0]  hashed_pcF,
   input  logic [BHT_DEPTH-1:0]  hashed_pc2F,
   input  logic                  pcsrcPF,
   input  logic                  resolveM,
   input  logic                  pcsrcM,
   output logic                  branch_upd,
   output logic [BHT_DEPTH-1:0]  hashed_pc_upd,
   output logic [BHT_DEPTH-1:0]  hashed_pc2_upd,
   output logic                  pcsrc_upd,
   output logic                  mispredict,
   output logic                  full,
   output logic                  empty,
   output logic [QDEPTH_LOG:0]   count,
   output logic                  ovf,
   output logic                  udf,
   output logic [15:0]           stat_resolved,
   output logic [15:0]           stat_mispred
);

   localparam int DEPTH = 1 << QDEPTH_LOG;
   localparam logic [QDEPTH_LOG:0] DEPTH_C = (QDEPTH_LOG+1)'(DEPTH);

   typedef logic [QDEPTH_LOG-1:0] ptr_t;

   logic [BHT_DEPTH-1:0] hpc_mem  [DEPTH];
   logic [BHT_DEPTH-1:0] hpc2_mem [DEPTH];
   logic                 pred_mem [DEPTH];

   ptr_t wr_ptr;
   ptr_t rd_ptr;

   logic pop;
   logic mis;
   logic push_ok;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign pop     = resolveM && !empty;
   assign mis     = pop && (pred_mem[rd_ptr] != pcsrcM);
   // A mispredict flushes younger entries, so a same-cycle push is wrong-path too.
   assign push_ok = pushF && (!full || pop) && !mis;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         hpc_mem[wr_ptr]  <= hashed_pcF;
         hpc2_mem[wr_ptr] <= hashed_pc2F;
         pred_mem[wr_ptr] <= pcsrcPF;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         branch_upd     <= 1'b0;
         mispredict     <= 1'b0;
         hashed_pc_upd  <= '0;
         hashed_pc2_upd <= '0;
         pcsrc_upd      <= 1'b0;
         ovf            <= 1'b0;
         udf            <= 1'b0;
      end else begin
         branch_upd <= pop;
         mispredict <= mis;
         if (pop) begin
            hashed_pc_upd  <= hpc_mem[rd_ptr];
            hashed_pc2_upd <= hpc2_mem[rd_ptr];
            pcsrc_upd      <= pcsrcM;
         end
         if (pushF && full && !pop)
            ovf <= 1'b1;
         if (resolveM && empty)
            udf <= 1'b1;

         if (mis) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (push_ok)
               wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)
               rd_ptr <= rd_ptr + ptr_t'(1);
            case ({push_ok, pop})
               2'b10:   count <= count + (QDEPTH_LOG+1)'(1);
               2'b01:   count <= count - (QDEPTH_LOG+1)'(1);
               default: count <= count;
            endcase
         end
      end
   end

`ifdef BP_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else begin
         if (pop)
            stat_resolved <= sat_inc(stat_resolved);
         if (mis)
            stat_mispred <= sat_inc(stat_mispred);
      end
   end
`else
   assign stat_resolved = '0;
   assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue; update word is {branch_upd, hpc, hpc2, pcsrc, mispredict}.
module tb_bp_resolve_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pushF = 1'b0;
   logic [2:0]  hashed_pcF = '0;
   logic [2:0]  hashed_pc2F = '0;
   logic        pcsrcPF = 1'b0;
   logic        resolveM = 1'b0;
   logic        pcsrcM = 1'b0;
   logic        branch_upd;
   logic [2:0]  hashed_pc_upd;
   logic [2:0]  hashed_pc2_upd;
   logic        pcsrc_upd;
   logic        mispredict;
   logic        full;
   logic        empty;
   logic [2:0]  count;
   logic        ovf;
   logic        udf;
   logic [15:0] stat_resolved;
   logic [15:0] stat_mispred;

   int errors = 0;
   int checks = 0;

   bp_resolve_queue #(.BHT_DEPTH(3), .QDEPTH_LOG(2)) dut (
      .clk(clk), .rst(rst), .pushF(pushF), .hashed_pcF(hashed_pcF), .hashed_pc2F(hashed_pc2F),
      .pcsrcPF(pcsrcPF), .resolveM(resolveM), .pcsrcM(pcsrcM), .branch_upd(branch_upd),
      .hashed_pc_upd(hashed_pc_upd), .hashed_pc2_upd(hashed_pc2_upd), .pcsrc_upd(pcsrc_upd),
      .mispredict(mispredict), .full(full), .empty(empty), .count(count), .ovf(ovf), .udf(udf),
      .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
   );

   always #5 clk = ~clk;

   logic [8:0] upd;
   assign upd = {branch_upd, hashed_pc_upd, hashed_pc2_upd, pcsrc_upd, mispredict};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pushF = 1'b0;
      resolveM = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   task automatic push(input logic [2:0] a, input logic [2:0] b, input logic p);
      pushF = 1'b1; hashed_pcF = a; hashed_pc2F = b; pcsrcPF = p; resolveM = 1'b0;
      cyc();
      pushF = 1'b0;
   endtask

   task automatic pop(input logic pc);
      resolveM = 1'b1; pcsrcM = pc; pushF = 1'b0;
      cyc();
      resolveM = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      #2;
      checks++; if ({empty, full, count} !== {1'b1, 1'b0, 3'd0}) begin errors++; $display("FAIL reset_status: got %b want %b", {empty, full, count}, 5'b10000); end
      checks++; if ({branch_upd, mispredict, ovf, udf} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {branch_upd, mispredict, ovf, udf}); end
      checks++; if ({stat_resolved, stat_mispred} !== 32'd0) begin errors++; $display("FAIL reset_stats: got %h want 0", {stat_resolved, stat_mispred}); end
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      apply_reset();
      push(3'd1, 3'd2, 1'b1);
      push(3'd3, 3'd4, 1'b0);
      push(3'd5, 3'd6, 1'b1);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL basic_count: got %0d want 3", count); end
      pop(1'b1);
      checks++; if (upd !== {1'b1, 3'd1, 3'd2, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_pop0: got %b want %b", upd, {1'b1, 3'd1, 3'd2, 1'b1, 1'b0}); end
      pop(1'b0);
      checks++; if (upd !== {1'b1, 3'd3, 3'd4, 1'b0, 1'b0}) begin errors++; $display("FAIL basic_pop1: got %b want %b", upd, {1'b1, 3'd3, 3'd4, 1'b0, 1'b0}); end
      pop(1'b1);
      checks++; if (upd !== {1'b1, 3'd5, 3'd6, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_pop2: got %b want %b", upd, {1'b1, 3'd5, 3'd6, 1'b1, 1'b0}); end
      cyc();
      checks++; if (upd !== {1'b0, 3'd5, 3'd6, 1'b1, 1'b0}) begin errors++; $display("FAIL basic_hold: got %b want %b", upd, {1'b0, 3'd5, 3'd6, 1'b1, 1'b0}); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", empty); end
   endtask

   task automatic test_full();
      apply_reset();
      for (int i = 0; i < 4; i++) push(3'(i), 3'(7 - i), 1'b1);
      checks++; if ({full, count} !== {1'b1, 3'd4}) begin errors++; $display("FAIL full_set: got %b want %b", {full, count}, 4'b1100); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_no_ovf: got %b want 0", ovf); end
      push(3'd6, 3'd6, 1'b1);
      checks++; if ({full, count, ovf} !== {1'b1, 3'd4, 1'b1}) begin errors++; $display("FAIL full_drop: got %b want %b", {full, count, ovf}, 5'b11001); end
   endtask

   task automatic test_wrap();
      pushF = 1'b1; hashed_pcF = 3'd7; hashed_pc2F = 3'd0; pcsrcPF = 1'b0;
      resolveM = 1'b1; pcsrcM = 1'b1;
      cyc();
      idle();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count: got %0d want 4", count); end
      checks++; if (upd !== {1'b1, 3'd0, 3'd7, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_pop0: got %b want %b", upd, {1'b1, 3'd0, 3'd7, 1'b1, 1'b0}); end
      pop(1'b1);
      checks++; if (upd !== {1'b1, 3'd1, 3'd6, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_pop1: got %b want %b", upd, {1'b1, 3'd1, 3'd6, 1'b1, 1'b0}); end
      pop(1'b1);
      checks++; if (upd !== {1'b1, 3'd2, 3'd5, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_pop2: got %b want %b", upd, {1'b1, 3'd2, 3'd5, 1'b1, 1'b0}); end
      pop(1'b1);
      checks++; if (upd !== {1'b1, 3'd3, 3'd4, 1'b1, 1'b0}) begin errors++; $display("FAIL wrap_pop3: got %b want %b", upd, {1'b1, 3'd3, 3'd4, 1'b1, 1'b0}); end
      pop(1'b0);
      checks++; if (upd !== {1'b1, 3'd7, 3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL wrap_pop4: got %b want %b", upd, {1'b1, 3'd7, 3'd0, 1'b0, 1'b0}); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
   endtask

   task automatic test_mispredict();
      apply_reset();
      push(3'd1, 3'd1, 1'b1);
      push(3'd2, 3'd2, 1'b0);
      push(3'd3, 3'd3, 1'b1);
      pushF = 1'b1; hashed_pcF = 3'd4; hashed_pc2F = 3'd4; pcsrcPF = 1'b1;
      resolveM = 1'b1; pcsrcM = 1'b0;
      cyc();
      idle();
      checks++; if (upd !== {1'b1, 3'd1, 3'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL mis_upd: got %b want %b", upd, {1'b1, 3'd1, 3'd1, 1'b0, 1'b1}); end
      checks++; if ({count, empty, ovf} !== {3'd0, 1'b1, 1'b0}) begin errors++; $display("FAIL mis_flush: got %b want %b", {count, empty, ovf}, 5'b00010); end
      cyc();
      checks++; if ({branch_upd, mispredict, count} !== {1'b0, 1'b0, 3'd0}) begin errors++; $display("FAIL mis_after: got %b want 00000", {branch_upd, mispredict, count}); end
      push(3'd5, 3'd5, 1'b0);
      pop(1'b0);
      checks++; if (upd !== {1'b1, 3'd5, 3'd5, 1'b0, 1'b0}) begin errors++; $display("FAIL mis_reuse: got %b want %b", upd, {1'b1, 3'd5, 3'd5, 1'b0, 1'b0}); end
   endtask

   task automatic test_underflow();
      apply_reset();
      pop(1'b1);
      checks++; if ({branch_upd, udf, empty} !== 3'b011) begin errors++; $display("FAIL udf_set: got %b want 011", {branch_upd, udf, empty}); end
      cyc();
      checks++; if (udf !== 1'b1) begin errors++; $display("FAIL udf_sticky: got %b want 1", udf); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      push(3'd1, 3'd2, 1'b1);
      push(3'd3, 3'd4, 1'b1);
      push(3'd5, 3'd6, 1'b1);
      pop(1'b1);
      checks++; if ({branch_upd, count} !== {1'b1, 3'd2}) begin errors++; $display("FAIL rmid_pre: got %b want 1010", {branch_upd, count}); end
      resolveM = 1'b1; pcsrcM = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      checks++; if ({branch_upd, count, empty, hashed_pc_upd} !== {1'b0, 3'd0, 1'b1, 3'd0}) begin errors++; $display("FAIL rmid_async: got %b want %b", {branch_upd, count, empty, hashed_pc_upd}, 8'b00001000); end
      cyc();
      cyc();
      checks++; if (branch_upd !== 1'b0) begin errors++; $display("FAIL rmid_held: got %b want 0", branch_upd); end
      idle();
      rst = 1'b1;
      cyc();
      pop(1'b1);
      checks++; if ({branch_upd, udf} !== 2'b01) begin errors++; $display("FAIL rmid_discard: got %b want 01", {branch_upd, udf}); end
   endtask

   task automatic test_stats();
`ifdef BP_STATS_EN
      apply_reset();
      push(3'd1, 3'd1, 1'b1);
      push(3'd2, 3'd2, 1'b1);
      push(3'd3, 3'd3, 1'b1);
      pop(1'b1);
      pop(1'b1);
      pop(1'b0);
      push(3'd4, 3'd4, 1'b0);
      push(3'd5, 3'd5, 1'b0);
      pop(1'b0);
      pop(1'b1);
      checks++; if ({stat_resolved, stat_mispred} !== {16'd5, 16'd2}) begin errors++; $display("FAIL stats_count: got %0d/%0d want 5/2", stat_resolved, stat_mispred); end
      force dut.stat_resolved = 16'hFFFE;
      force dut.stat_mispred = 16'hFFFE;
      #1;
      release dut.stat_resolved;
      release dut.stat_mispred;
      push(3'd1, 3'd1, 1'b1);
      pop(1'b0);
      push(3'd2, 3'd2, 1'b1);
      pop(1'b0);
      checks++; if ({stat_resolved, stat_mispred} !== {16'hFFFF, 16'hFFFF}) begin errors++; $display("FAIL stats_sat: got %h/%h want ffff/ffff", stat_resolved, stat_mispred); end
`else
      push(3'd1, 3'd1, 1'b1);
      pop(1'b0);
      checks++; if ({stat_resolved, stat_mispred} !== 32'd0) begin errors++; $display("FAIL stats_tied: got %h/%h want 0/0", stat_resolved, stat_mispred); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_wrap();
      test_mispredict();
      test_underflow();
      test_reset_mid();
      test_stats();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
